squeeze_stage: RTL and testbench
================================

// Module: squeeze_stage
// PURPOSE
//  Output side of the Keccak sponge. After the permutation core finishes, it captures the rate lanes
//  of the 1600-bit state and streams them out as 64-bit words over a valid/ready interface.
//  Requests longer than one rate block (extendable output) trigger further permutations via perm_req,
//  and the block waits for each new state before continuing.
// PARAMETERS
//  RATE_LANES  17  lanes per rate block (1088 bits / 64); legal range 1..25
//  LEN_W       8   width of out_len; maximum request is 2^LEN_W-1 words
// PORTS
//  clk          in   1     clock; all logic on the rising edge
//  rst          in   1     synchronous reset, active-high
//  start        in   1     1-cycle pulse that begins a squeeze of out_len words
//  out_len      in   LEN_W number of 64-bit words to emit; sampled on start
//  state_in     in   1600  permuted state; lane L = state_in[64*L +: 64], with L = 5*y+x
//  state_valid  in   1     1-cycle pulse: state_in holds a completed permutation
//  perm_req     out  1     1-cycle pulse: request one more permutation of the current state
//  out_data     out  64    output word, first message byte in [63:56]
//  out_valid    out  1     out_data is valid
//  out_ready    in   1     downstream accepts out_data
//  out_last     out  1     qualifies out_valid; marks the final word of the request
//  busy         out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=1 at an edge): FSM to IDLE; perm_req, out_valid, out_last and busy = 0; out_data = 0.
//  Counters word_cnt and lane_idx and the buffer clear to 0. Reset overrides all other inputs,
//  including during EMIT; a word offered but not yet accepted is dropped.
//  FSM states: IDLE, WAIT_STATE, EMIT, REQ_PERM.
//  IDLE:
//   - start=1 with out_len!=0: latch len=out_len, word_cnt=0, go to WAIT_STATE.
//   - start with out_len==0 is ignored.
//   - state_valid is ignored in IDLE, including in the same cycle as start.
//  WAIT_STATE: when state_valid=1, register lanes 0..RATE_LANES-1 into buf[64*RATE_LANES-1:0],
//   set lane_idx=0 and go to EMIT.
//  EMIT:
//   - out_valid=1; out_data = byteswap64(buf lane lane_idx), i.e. lane byte 0 (bits [7:0]) goes
//     to [63:56]. This matches the big-endian block convention used on the absorb input.
//   - out_last = (word_cnt == len-1).
//   - On a handshake (out_valid && out_ready): word_cnt++ and lane_idx++. Then:
//     if that was the last word, go to IDLE;
//     else if lane_idx was RATE_LANES-1, go to REQ_PERM;
//     else stay in EMIT.
//   - Without a handshake, out_data and out_last hold stable and out_valid stays high.
//  REQ_PERM: perm_req=1 for exactly one cycle, then go to WAIT_STATE.
//  Latency: state_valid at edge t gives out_valid=1 after edge t+1 (one register stage).
//   With out_ready held high, one word is emitted per cycle.
//  start is ignored while busy=1. state_valid is ignored outside WAIT_STATE.
//  out_data, out_valid, out_last and perm_req are all registered outputs.
//  Words are emitted in lane order 0,1,2,...; each new block restarts at lane 0.
//  Width rules: word_cnt is LEN_W bits wide and cannot wrap, since len <= 2^LEN_W-1.
//   lane_idx is 5 bits wide, counts 0..RATE_LANES-1 and is reset in WAIT_STATE.
// TESTING
//  T1 Byteswap: lane0=64'h0123456789ABCDEF; start with out_len=1, then state_valid
//     -> one word 64'hEFCDAB8967452301 with out_last=1; busy falls the next cycle.
//  T2 Digest: lanes 0..3 = 64'h1..64'h4; out_len=4; out_ready=1
//     -> 4 consecutive words 64'h0100..00 to 64'h0400..00 (byteswapped); last on word 4; no perm_req.
//  T3 XOF: out_len=20
//     -> 17 words, then a single perm_req pulse; after the second state_valid, 3 more words
//        from lanes 0..2 of the new state; out_last on word 20.
//  T4 Backpressure: hold out_ready=0 for 3 cycles on word 2
//     -> out_data and out_last stable and out_valid=1 throughout; no word lost or duplicated.
//  T5 Ignored inputs:
//     -> start with out_len=0: no busy.
//     -> start during EMIT: no effect.
//     -> state_valid in IDLE or EMIT: buffer unchanged.
//  T6 Reset mid-EMIT: assert rst after 2 of 4 words
//     -> all outputs 0 the next cycle; a fresh start/state_valid then emits from lane 0.

Source files
------------

// File: rtl/squeeze_stage.sv
`default_nettype none
// ============================================================================
//  Module   : squeeze_stage
//  Captures the rate lanes of a permuted Keccak state and streams them out as
//  byte-swapped 64-bit words, requesting further permutations for long outputs.
//  Revision : 1.0
// ============================================================================
module squeeze_stage #(
    parameter int RATE_LANES = 17,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  out_len,
    input  logic [1599:0]     state_in,
    input  logic              state_valid,
    output logic              perm_req,
    output logic [63:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT_STATE = 2'd1;
    localparam logic [1:0] c_EMIT       = 2'd2;
    localparam logic [1:0] c_REQ_PERM   = 2'd3;

    localparam int               c_BUF_W     = 64 * RATE_LANES;
    localparam logic [4:0]       c_LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);

    logic [1:0]         r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [4:0]         r_lane_idx;
    logic [c_BUF_W-1:0] r_buf;
    logic [63:0]        r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_perm_req;

    logic [4:0]         w_next_lane_idx;
    logic [LEN_W-1:0]   w_next_cnt;
    logic [LEN_W-1:0]   w_len_m1;
    logic [63:0]        w_cur_lane;
    logic [63:0]        w_next_lane;

    // Lane byte 0 lands in the most significant byte of the output word.
    function automatic logic [63:0] f_byteswap(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = w[8*(7-b) +: 8];
        end
        return r;
    endfunction

    assign w_next_lane_idx = r_lane_idx + 5'd1;
    assign w_next_cnt      = r_word_cnt + c_ONE;
    assign w_len_m1        = r_len - c_ONE;
    assign w_cur_lane      = r_buf[64*r_lane_idx +: 64];
    assign w_next_lane     = r_buf[64*w_next_lane_idx +: 64];

    // Capacity lanes never leave the sponge.
    generate
        if (RATE_LANES < 25) begin : g_unused_lanes
            logic w_unused_capacity;
            assign w_unused_capacity = ^state_in[1599:c_BUF_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_lane_idx  <= '0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_perm_req  <= 1'b0;
        end else begin
            r_perm_req <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && (out_len != '0)) begin
                        r_len      <= out_len;
                        r_word_cnt <= '0;
                        r_state    <= c_WAIT_STATE;
                    end
                end
                c_WAIT_STATE: begin
                    if (state_valid) begin
                        r_buf      <= state_in[c_BUF_W-1:0];
                        r_lane_idx <= '0;
                        r_state    <= c_EMIT;
                    end
                end
                c_EMIT: begin
                    if (!r_out_valid) begin
                        // First word of a block comes one cycle after capture.
                        r_out_valid <= 1'b1;
                        r_out_data  <= f_byteswap(w_cur_lane);
                        r_out_last  <= (r_word_cnt == w_len_m1);
                    end else if (out_ready) begin
                        r_word_cnt <= w_next_cnt;
                        r_lane_idx <= w_next_lane_idx;
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= c_IDLE;
                        end else if (r_lane_idx == c_LAST_LANE) begin
                            r_out_valid <= 1'b0;
                            r_perm_req  <= 1'b1;
                            r_state     <= c_REQ_PERM;
                        end else begin
                            r_out_data <= f_byteswap(w_next_lane);
                            r_out_last <= (w_next_cnt == w_len_m1);
                        end
                    end
                end
                c_REQ_PERM: begin
                    r_state <= c_WAIT_STATE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign perm_req  = r_perm_req;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_squeeze_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_squeeze_stage
//  Directed self-checking bench for squeeze_stage.
//  Revision : 1.0
// ============================================================================
module tb_squeeze_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    out_len;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          perm_req;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    int vectors    = 0;
    int miscompares = 0;

    squeeze_stage #(.RATE_LANES(17), .LEN_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .out_len     (out_len),
        .state_in    (state_in),
        .state_valid (state_valid),
        .perm_req    (perm_req),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bswap(input logic [63:0] w);
        logic [63:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [63:0] base);
        for (int l = 0; l < 25; l++) state_in[64*l +: 64] = base + 64'(l);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic begin_squeeze(input logic [7:0] len);
        start = 1'b1; out_len = len;
        tick();
        start = 1'b0;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_len = '0; state_in = '0;
        state_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_busy",  {63'd0, busy}, 64'd0);
        chk("reset_data",  out_data, 64'd0);
        chk("reset_perm",  {63'd0, perm_req}, 64'd0);

        // T1: single byteswapped word
        state_in = '0;
        state_in[63:0] = 64'h0123456789ABCDEF;
        start = 1'b1; out_len = 8'd1;
        tick();
        start = 1'b0;
        chk("t1_busy_wait", {63'd0, busy}, 64'd1);
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        chk("t1_latency", {63'd0, out_valid}, 64'd0);
        tick();
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_data", out_data, 64'hEFCDAB8967452301);
        chk("t1_last", {63'd0, out_last}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("t1_done_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_done_busy",  {63'd0, busy}, 64'd0);

        // T2: 4-word digest
        set_lanes(64'd1);
        begin_squeeze(8'd4);
        wait_valid("t2_timeout");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_data%0d", i), out_data, {8'(i + 1), 56'h0});
            chk($sformatf("t2_last%0d", i), {63'd0, out_last}, {63'd0, i == 3});
            chk($sformatf("t2_perm%0d", i), {63'd0, perm_req}, 64'd0);
            tick();
        end
        chk("t2_idle", {63'd0, busy}, 64'd0);

        // T3: extendable output spanning two blocks
        set_lanes(64'hA0A0_A0A0_0000_0000);
        begin_squeeze(8'd20);
        wait_valid("t3_timeout_a");
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t3_data%0d", i), out_data, bswap(64'hA0A0_A0A0_0000_0000 + 64'(i)));
            chk($sformatf("t3_last%0d", i), {63'd0, out_last}, 64'd0);
            tick();
        end
        chk("t3_perm_hi", {63'd0, perm_req}, 64'd1);
        chk("t3_gap_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("t3_perm_lo", {63'd0, perm_req}, 64'd0);
        set_lanes(64'h5B5B_0000_0000_0000);
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        wait_valid("t3_timeout_b");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_data%0d", 17 + i), out_data, bswap(64'h5B5B_0000_0000_0000 + 64'(i)));
            chk($sformatf("t3_last%0d", 17 + i), {63'd0, out_last}, {63'd0, i == 2});
            tick();
        end
        chk("t3_idle", {63'd0, busy}, 64'd0);
        chk("t3_no_perm", {63'd0, perm_req}, 64'd0);

        // T4/T5: backpressure on word 2, with start and state_valid during EMIT
        set_lanes(64'h1111_0000_0000_0010);
        begin_squeeze(8'd4);
        wait_valid("t4_timeout");
        chk("t4_w0", out_data, bswap(64'h1111_0000_0000_0010));
        tick();
        out_ready = 1'b0;
        set_lanes(64'hDEAD_0000_0000_0000);
        for (int c = 0; c < 3; c++) begin
            start = (c == 0); out_len = 8'd1;
            state_valid = (c == 1);
            tick();
            start = 1'b0; state_valid = 1'b0;
            chk($sformatf("t4_hold_valid%0d", c), {63'd0, out_valid}, 64'd1);
            chk($sformatf("t4_hold_data%0d", c), out_data, bswap(64'h1111_0000_0000_0011));
            chk($sformatf("t4_hold_last%0d", c), {63'd0, out_last}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_w2", out_data, bswap(64'h1111_0000_0000_0012));
        tick();
        chk("t4_w3", out_data, bswap(64'h1111_0000_0000_0013));
        chk("t4_w3_last", {63'd0, out_last}, 64'd1);
        tick();
        chk("t4_idle", {63'd0, busy}, 64'd0);
        tick();
        chk("t5_no_restart", {63'd0, busy}, 64'd0);

        // T5: zero-length start ignored
        start = 1'b1; out_len = 8'd0;
        tick();
        start = 1'b0;
        chk("t5_len0_busy", {63'd0, busy}, 64'd0);

        // T5: state_valid coincident with start is not captured
        set_lanes(64'hBAD0_0000_0000_0000);
        start = 1'b1; out_len = 8'd1; state_valid = 1'b1;
        tick();
        start = 1'b0; state_valid = 1'b0;
        tick();
        chk("t5_wait_no_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_wait_busy", {63'd0, busy}, 64'd1);
        set_lanes(64'h600D_0000_0000_0000);
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        wait_valid("t5_timeout");
        chk("t5_fresh_data", out_data, bswap(64'h600D_0000_0000_0000));
        tick();

        // T6: reset in the middle of a 4-word emit
        set_lanes(64'h7700_0000_0000_0000);
        begin_squeeze(8'd4);
        wait_valid("t6_timeout");
        tick(); tick();
        chk("t6_pre_reset", out_data, bswap(64'h7700_0000_0000_0002));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_data",  out_data, 64'd0);
        chk("t6_last",  {63'd0, out_last}, 64'd0);
        chk("t6_busy",  {63'd0, busy}, 64'd0);
        chk("t6_perm",  {63'd0, perm_req}, 64'd0);
        set_lanes(64'h8800_0000_0000_0000);
        begin_squeeze(8'd2);
        wait_valid("t6_timeout_b");
        chk("t6_restart_w0", out_data, bswap(64'h8800_0000_0000_0000));
        tick();
        chk("t6_restart_w1", out_data, bswap(64'h8800_0000_0000_0001));
        chk("t6_restart_last", {63'd0, out_last}, 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
